// File: rtl/memory_arbiter_pkg.sv
// Shared helpers for the two-master memory arbiter.
package memory_arbiter_pkg;

  // A requester is active while it asks for either a read or a write.
  function automatic logic req_active(input logic rd_en, input logic wr_en);
    return rd_en | wr_en;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: the requester that did not
// hold the last grant wins a tie.
module rr_pick2 (
  input  logic [1:0] active,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Tie goes to the requester other than last_grant; otherwise the lone one.
  always_comb begin
    grant_valid = |active;
    if (&active) grant_idx = ~last_grant;
    else         grant_idx = active[1];
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between the core (req0) and a secondary master
// (req1). Grants are registered and held until mem_ack or withdrawal, so a
// multi-cycle memory transaction is never interleaved with the other master.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0_rd_en,
  input  logic                    req0_wr_en,
  input  logic [DATA_WIDTH/8-1:0] req0_byte_en,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wr_data,
  output logic [DATA_WIDTH-1:0]   req0_rd_data,
  output logic                    req0_ack,
  input  logic                    req1_rd_en,
  input  logic                    req1_wr_en,
  input  logic [DATA_WIDTH/8-1:0] req1_byte_en,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wr_data,
  output logic [DATA_WIDTH-1:0]   req1_rd_data,
  output logic                    req1_ack,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic                    mem_ack
);

  localparam int BYTE_NUM = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic [1:0] active;
  logic       grant_valid;
  logic       grant_idx;

  assign active[0] = req_active(req0_rd_en, req0_wr_en);
  assign active[1] = req_active(req1_rd_en, req1_wr_en);

  rr_pick2 u_pick (
    .active      (active),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Grant FSM: pick in Idle, release on ack or when the owner withdraws.
  // Every release passes through Idle, giving one dead cycle per transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (grant_valid) state <= grant_idx ? GRANT1 : GRANT0;
        GRANT0:
          if (mem_ack || !active[0]) begin
            state      <= IDLE;
            last_grant <= 1'b0;
          end
        GRANT1:
          if (mem_ack || !active[1]) begin
            state      <= IDLE;
            last_grant <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner to memory; Idle drives zeros and swallows stray acks.
  // Outputs decode only from state, so async reset silences them at once.
  always_comb begin
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_byte_en  = '0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    req0_ack     = 1'b0;
    req0_rd_data = '0;
    req1_ack     = 1'b0;
    req1_rd_data = '0;
    case (state)
      GRANT0: begin
        mem_rd_en    = req0_rd_en;
        mem_wr_en    = req0_wr_en;
        mem_byte_en  = req0_byte_en;
        mem_addr     = req0_addr;
        mem_wr_data  = req0_wr_data;
        req0_ack     = mem_ack;
        req0_rd_data = mem_rd_data;
      end
      GRANT1: begin
        mem_rd_en    = req1_rd_en;
        mem_wr_en    = req1_wr_en;
        mem_byte_en  = req1_byte_en;
        mem_addr     = req1_addr;
        mem_wr_data  = req1_wr_data;
        req1_ack     = mem_ack;
        req1_rd_data = mem_rd_data;
      end
      default: ;
    endcase
  end

  logic unused_width;
  assign unused_width = (BYTE_NUM == 0);

endmodule
